// File: rtl/riscv_pkg.sv
// Shared RISC-V load definitions: funct3 load encodings, load-unit FSM states
// and the misalignment rule used when LOAD_UNIT_MISALIGN_TRAP_EN is defined.
package riscv_pkg;

   localparam int unsigned RV_XLEN = 32;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      WB    = 3'd3,
      FAULT = 3'd4
   } load_state_t;

   // Halfwords need 2-byte alignment, words 4-byte; bytes never fault.
   function automatic logic is_misaligned(input logic [2:0] ctl, input logic [1:0] ea_lo);
      logic r;
      r = 1'b0;
      case (ctl)
         LH, LHU: r = ea_lo[0];
         LW:      r = |ea_lo;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the byte/halfword lane out of a read word and sign- or zero-extends it.
module load_align_ext
   import riscv_pkg::*;
(
   input  logic [RV_XLEN-1:0] i_word,
   input  logic [1:0]         i_ea_lo,
   input  logic [2:0]         i_load_control,
   output logic [RV_XLEN-1:0] o_data_c
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte   = 8'h00;
      w_half   = 16'h0000;
      o_data_c = '0;
      case (i_ea_lo)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half = i_ea_lo[1] ? i_word[31:16] : i_word[15:0];
      // Unknown codes fall through to LB.
      case (i_load_control)
         LH:      o_data_c = {{16{w_half[15]}}, w_half};
         LW:      o_data_c = i_word;
         LBU:     o_data_c = {24'h000000, w_byte};
         LHU:     o_data_c = {16'h0000, w_half};
         default: o_data_c = {{24{w_byte[7]}}, w_byte};
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Load execute/memory stage: one outstanding word-aligned read, lane extract and writeback.
// Optional misaligned-load trap via `define LOAD_UNIT_MISALIGN_TRAP_EN.
module load_unit
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_rs1_val,
   input  logic [11:0]       in_imm,
   input  logic [4:0]        in_rd,
   input  logic [2:0]        in_load_control,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic              fault_valid,
   output logic [XLEN-1:0]   fault_addr
);

   load_state_t       r_state;
   load_state_t       w_state_nxt;
   logic [4:0]        r_rd;
   logic [2:0]        r_ctl;
   logic [XLEN-1:0]   r_ea;

   logic              r_in_ready;
   logic              r_mem_req_valid;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_wb_valid;
   logic [4:0]        r_wb_rd;
   logic [XLEN-1:0]   r_wb_data;

   logic              w_accept;
   logic              w_trap;
   logic [XLEN-1:0]   w_ea_in;
   logic [XLEN-1:0]   w_ea_nxt;
   logic [XLEN-1:0]   w_ext_c;
   logic              w_in_ready_nxt;
   logic              w_req_valid_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              w_wb_valid_nxt;
   logic [4:0]        w_wb_rd_nxt;
   logic [XLEN-1:0]   w_wb_data_nxt;

   assign w_accept = in_valid && r_in_ready;
   assign w_ea_in  = in_rs1_val + {{(XLEN-12){in_imm[11]}}, in_imm};

`ifdef LOAD_UNIT_MISALIGN_TRAP_EN
   assign w_trap = is_misaligned(in_load_control, w_ea_in[1:0]);
`else
   assign w_trap = 1'b0;
`endif

   // Response word is extended on the way into the writeback registers.
   load_align_ext u_align_ext (
      .i_word         (mem_rdata),
      .i_ea_lo        (r_ea[1:0]),
      .i_load_control (r_ctl),
      .o_data_c       (w_ext_c)
   );

   // Next state plus next values of the registered outputs.
   always_comb begin
      w_state_nxt     = r_state;
      w_ea_nxt        = r_ea;
      w_in_ready_nxt  = 1'b0;
      w_req_valid_nxt = 1'b0;
      w_addr_nxt      = '0;
      w_wb_valid_nxt  = 1'b0;
      w_wb_rd_nxt     = '0;
      w_wb_data_nxt   = '0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_ea_nxt    = w_ea_in;
               w_state_nxt = w_trap ? FAULT : REQ;
            end
         end
         REQ:     if (mem_req_ready) w_state_nxt = WAIT;
         WAIT:    if (mem_rsp_valid) w_state_nxt = WB;
         WB:      w_state_nxt = IDLE;
         FAULT:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      w_in_ready_nxt  = (w_state_nxt == IDLE);
      w_req_valid_nxt = (w_state_nxt == REQ);
      if (w_state_nxt == REQ) w_addr_nxt = ADDR_W'({w_ea_nxt[XLEN-1:2], 2'b00});
      if (w_state_nxt == WB) begin
         w_wb_valid_nxt = 1'b1;
         w_wb_rd_nxt    = r_rd;
         w_wb_data_nxt  = w_ext_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_rd            <= '0;
         r_ctl           <= '0;
         r_ea            <= '0;
         r_in_ready      <= 1'b1;
         r_mem_req_valid <= 1'b0;
         r_mem_addr      <= '0;
         r_wb_valid      <= 1'b0;
         r_wb_rd         <= '0;
         r_wb_data       <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_ea            <= w_ea_nxt;
         if (w_accept) begin
            r_rd  <= in_rd;
            r_ctl <= in_load_control;
         end
         r_in_ready      <= w_in_ready_nxt;
         r_mem_req_valid <= w_req_valid_nxt;
         r_mem_addr      <= w_addr_nxt;
         r_wb_valid      <= w_wb_valid_nxt;
         r_wb_rd         <= w_wb_rd_nxt;
         r_wb_data       <= w_wb_data_nxt;
      end
   end

`ifdef LOAD_UNIT_MISALIGN_TRAP_EN
   logic            r_fault_valid;
   logic [XLEN-1:0] r_fault_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault_valid <= 1'b0;
         r_fault_addr  <= '0;
      end else begin
         r_fault_valid <= (w_state_nxt == FAULT);
         r_fault_addr  <= (w_state_nxt == FAULT) ? w_ea_nxt : '0;
      end
   end

   assign fault_valid = r_fault_valid;
   assign fault_addr  = r_fault_addr;
`else
   assign fault_valid = 1'b0;
   assign fault_addr  = '0;
`endif

   assign in_ready      = r_in_ready;
   assign mem_req_valid = r_mem_req_valid;
   assign mem_addr      = r_mem_addr;
   assign wb_valid      = r_wb_valid;
   assign wb_rd         = r_wb_rd;
   assign wb_data       = r_wb_data;

endmodule
